// File: rtl/vid_palette_dbuf.sv
// vid_palette_dbuf: double-buffered video palette.
// The video side reads the front bank, the bus side writes the back bank.
// A requested bank swap is held pending and committed on the next
// frame_start, so the palette never changes in the middle of a frame.
// Optional feature macro: VID_PALETTE_DBUF_CLEAR_EN adds clr_req and a CLEAR
// state that zeroes the whole back bank, one entry per cycle.
module vid_palette_dbuf #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          w_ena,
    output logic          w_ready,
    input  logic          swap_req,
    output logic          swap_pending,
    input  logic          frame_start,
`ifdef VID_PALETTE_DBUF_CLEAR_EN
    input  logic          clr_req,
`endif
    input  logic [AW-1:0] r_addr_0,
    input  logic          r_valid_0,
    output logic [DW-1:0] r_data_n,
    output logic          r_valid_n,
    output logic          bank_sel
);

    localparam int DEPTH = 2 ** (AW + 1);

`ifdef VID_PALETTE_DBUF_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_CLEAR} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_PENDING} state_t;
`endif

    state_t          state_q, state_d;
    logic            bank_sel_q, bank_sel_d;
    logic            ram_we;
    logic [AW:0]     ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   mem [0:DEPTH-1];
    logic [DW-1:0]   rd1_q;
    logic            vld1_q;

`ifdef VID_PALETTE_DBUF_CLEAR_EN
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_we;
`endif

    // Swap/clear state register; reset abandons any pending swap or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bank_sel_q <= 1'b0;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
            clr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

    // Next-state logic: swap_req waits for a later frame_start, even when the
    // two arrive together, and extra requests while pending are ignored.
    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
        clr_cnt_d  = clr_cnt_q;
        clr_we     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (swap_req) begin
                    state_d = S_PENDING;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
                end else if (clr_req) begin
                    // swap_req wins if both arrive in the same cycle
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
`endif
                end
            end
            S_PENDING: begin
                if (frame_start) begin
                    bank_sel_d = ~bank_sel_q;
                    state_d    = S_IDLE;
                end
            end
`ifdef VID_PALETTE_DBUF_CLEAR_EN
            S_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == '1) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign w_ready      = (state_q == S_IDLE);
    assign swap_pending = (state_q == S_PENDING);
    assign bank_sel     = bank_sel_q;

    // RAM write port mux: bus writes only when ready, clear owns it otherwise.
    always_comb begin
        ram_we    = w_ena && w_ready;
        ram_waddr = {~bank_sel_q, w_addr};
        ram_wdata = w_data;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
        if (clr_we) begin
            ram_we    = 1'b1;
            ram_waddr = {~bank_sel_q, clr_cnt_q};
            ram_wdata = '0;
        end
`endif
    end

    // Storage: both banks in one RAM, back bank always opposite the reader.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    // First read stage: registered RAM output, held while no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q  <= '0;
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= r_valid_0;
            if (r_valid_0) rd1_q <= mem[{bank_sel_q, r_addr_0}];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] rd2_q;
            logic          vld2_q;
            // Optional second output register for timing relief.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd2_q  <= '0;
                    vld2_q <= 1'b0;
                end else begin
                    vld2_q <= vld1_q;
                    if (vld1_q) rd2_q <= rd1_q;
                end
            end
            assign r_data_n  = rd2_q;
            assign r_valid_n = vld2_q;
        end else begin : g_lat1
            assign r_data_n  = rd1_q;
            assign r_valid_n = vld1_q;
        end
    endgenerate

endmodule

// File: tb/tb_vid_palette_dbuf.sv
// Bench for vid_palette_dbuf: one instance at RD_LAT=1 and one at RD_LAT=2
// share the same stimulus. A bank-array model checks outputs every cycle;
// directed steps add literal expectations.
module tb_vid_palette_dbuf;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] w_addr, r_addr_0;
    logic [DW-1:0] w_data;
    logic          w_ena, swap_req, frame_start, r_valid_0;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
    logic          clr_req;
`endif
    logic          w_ready1, swap_pending1, r_valid_n1, bank_sel1;
    logic          w_ready2, swap_pending2, r_valid_n2, bank_sel2;
    logic [DW-1:0] r_data_n1, r_data_n2;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    vid_palette_dbuf #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data), .w_ena(w_ena),
        .w_ready(w_ready1), .swap_req(swap_req), .swap_pending(swap_pending1),
        .frame_start(frame_start),
`ifdef VID_PALETTE_DBUF_CLEAR_EN
        .clr_req(clr_req),
`endif
        .r_addr_0(r_addr_0), .r_valid_0(r_valid_0), .r_data_n(r_data_n1),
        .r_valid_n(r_valid_n1), .bank_sel(bank_sel1));

    vid_palette_dbuf #(.AW(AW), .DW(DW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_data(w_data), .w_ena(w_ena),
        .w_ready(w_ready2), .swap_req(swap_req), .swap_pending(swap_pending2),
        .frame_start(frame_start),
`ifdef VID_PALETTE_DBUF_CLEAR_EN
        .clr_req(clr_req),
`endif
        .r_addr_0(r_addr_0), .r_valid_0(r_valid_0), .r_data_n(r_data_n2),
        .r_valid_n(r_valid_n2), .bank_sel(bank_sel2));

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mbank [2][256];
    bit            mknown [2][256];
    bit            m_sel, m_pend, m_live, m_idle;
    int            m_clr_left;
    bit            h_v [2];
    bit            h_k [2];
    logic [DW-1:0] h_d [2];
    logic [DW-1:0] o_d [2];
    bit            o_k [2];

    always @(posedge clk) begin
        if (rst) begin
            m_sel = 0; m_pend = 0; m_clr_left = 0; m_live = 1;
            for (int i = 0; i < 2; i++) begin
                h_v[i] = 0; h_k[i] = 1; h_d[i] = '0; o_d[i] = '0; o_k[i] = 1;
            end
        end else begin
            m_idle = !m_pend && (m_clr_left == 0);
            // delay line of reads: slot i is what a latency-(i+1) reader shows
            h_v[1] = h_v[0]; h_d[1] = h_d[0]; h_k[1] = h_k[0];
            h_v[0] = r_valid_0;
            h_d[0] = mbank[m_sel][r_addr_0];
            h_k[0] = mknown[m_sel][r_addr_0];
            for (int i = 0; i < 2; i++)
                if (h_v[i]) begin o_d[i] = h_d[i]; o_k[i] = h_k[i]; end
            if (w_ena && m_idle) begin
                mbank[m_sel ^ 1'b1][w_addr] = w_data;
                mknown[m_sel ^ 1'b1][w_addr] = 1;
            end
            if (m_clr_left > 0) begin
                mbank[m_sel ^ 1'b1][256 - m_clr_left] = '0;
                mknown[m_sel ^ 1'b1][256 - m_clr_left] = 1;
                m_clr_left--;
            end
            if (m_pend) begin
                if (frame_start) begin m_sel = !m_sel; m_pend = 0; end
            end else if (m_idle && swap_req) begin
                m_pend = 1;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
            end else if (m_idle && clr_req) begin
                m_clr_left = 256;
`endif
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("bank_sel1", 16'(bank_sel1), 16'(m_sel));
            chk("bank_sel2", 16'(bank_sel2), 16'(m_sel));
            chk("swap_pending1", 16'(swap_pending1), 16'(m_pend));
            chk("swap_pending2", 16'(swap_pending2), 16'(m_pend));
            chk("w_ready1", 16'(w_ready1), 16'(!m_pend && m_clr_left == 0));
            chk("w_ready2", 16'(w_ready2), 16'(!m_pend && m_clr_left == 0));
            chk("r_valid_n1", 16'(r_valid_n1), 16'(h_v[0]));
            chk("r_valid_n2", 16'(r_valid_n2), 16'(h_v[1]));
            if (o_k[0]) chk("r_data_n1", r_data_n1, o_d[0]);
            if (o_k[1]) chk("r_data_n2", r_data_n2, o_d[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_addr = a; w_data = d; w_ena = 1; step(); w_ena = 0;
    endtask

    task automatic pulse_swap();
        swap_req = 1; step(); swap_req = 0;
    endtask

    task automatic pulse_frame();
        frame_start = 1; step(); frame_start = 0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d1, output logic [DW-1:0] d2);
        r_addr_0 = a; r_valid_0 = 1; step(); d1 = r_data_n1;
        r_valid_0 = 0; step(); d2 = r_data_n2;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    logic [AW-1:0] t_addr [4] = '{8'h00, 8'hFF, 8'h80, 8'h10};
    logic [DW-1:0] t_data [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h5555};

    initial begin
        logic [DW-1:0] d1, d2;
        int cnt, bad;
        rst = 1; w_addr = '0; w_data = '0; w_ena = 0; swap_req = 0;
        frame_start = 0; r_addr_0 = '0; r_valid_0 = 0;
`ifdef VID_PALETTE_DBUF_CLEAR_EN
        clr_req = 0;
`endif
        repeat (3) step();
        rst = 0;
        chk("reset bank_sel", 16'(bank_sel1), 16'd0);
        chk("reset swap_pending", 16'(swap_pending1), 16'd0);
        chk("reset w_ready", 16'(w_ready2), 16'd1);
        chk("reset r_valid_n", 16'(r_valid_n2), 16'd0);
        chk("reset r_data_n", r_data_n2, 16'h0000);

        // first swap: bank1 becomes front holding 0xAAAA at 0x05
        wr(8'h05, 16'hAAAA);
        pulse_swap();
        chk("pending after swap_req", 16'(swap_pending1), 16'd1);
        chk("w_ready in pending", 16'(w_ready1), 16'd0);
        pulse_frame();
        chk("bank_sel after commit", 16'(bank_sel1), 16'd1);

        // back bank0 gets 0x1234; old value persists until the toggle
        wr(8'h05, 16'h1234);
        pulse_swap();
        r_addr_0 = 8'h05; r_valid_0 = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("old front before frame", r_data_n1, 16'hAAAA);
        end
        frame_start = 1; step(); frame_start = 0;
        chk("read in toggle cycle", r_data_n1, 16'hAAAA);
        chk("r_valid_n1 streaming", 16'(r_valid_n1), 16'd1);
        step();
        chk("new front lat1", r_data_n1, 16'h1234);
        chk("lat2 still old", r_data_n2, 16'hAAAA);
        step();
        chk("new front lat2", r_data_n2, 16'h1234);
        chk("bank_sel after 2nd swap", 16'(bank_sel1), 16'd0);
        r_valid_0 = 0; step();
        chk("r_valid_n1 drops", 16'(r_valid_n1), 16'd0);
        chk("r_data_n1 holds", r_data_n1, 16'h1234);

        // table writes to back, dropped write during pending, then read back
        for (int i = 0; i < 4; i++) wr(t_addr[i], t_data[i]);
        pulse_swap();
        wr(8'h10, 16'hDEAD);
        pulse_frame();
        for (int i = 0; i < 4; i++) begin
            rd(t_addr[i], d1, d2);
            chk("table read lat1", d1, t_data[i]);
            chk("table read lat2", d2, t_data[i]);
        end

        // swap_req coincident with frame_start only arms the swap
        swap_req = 1; frame_start = 1; step(); swap_req = 0; frame_start = 0;
        chk("coincident pending", 16'(swap_pending1), 16'd1);
        chk("coincident bank_sel", 16'(bank_sel1), 16'd1);
        step();
        pulse_frame();
        chk("coincident commits later", 16'(bank_sel1), 16'd0);

        // reset while pending with bank_sel=1
        pulse_swap(); pulse_frame();
        pulse_swap();
        chk("pre-reset bank_sel", 16'(bank_sel1), 16'd1);
        rst = 1; step(); rst = 0;
        chk("reset mid-pending swap_pending", 16'(swap_pending1), 16'd0);
        chk("reset mid-pending bank_sel", 16'(bank_sel1), 16'd0);
        chk("reset mid-pending w_ready", 16'(w_ready1), 16'd1);
        step();

`ifdef VID_PALETTE_DBUF_CLEAR_EN
        for (int i = 0; i < 256; i++) wr(8'(i), 16'hFFFF);
        clr_req = 1; step(); clr_req = 0;
        cnt = 0;
        while (!w_ready1 && cnt < 400) begin
            swap_req = (cnt == 10);
            step();
            swap_req = 0;
            cnt++;
        end
        chk("clear w_ready low cycles", 16'(cnt), 16'd256);
        chk("swap during clear ignored", 16'(swap_pending1), 16'd0);
        pulse_swap(); pulse_frame();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            rd(8'(i), d1, d2);
            if (d1 !== 16'h0000 || d2 !== 16'h0000) bad++;
        end
        chk("cleared entries nonzero", 16'(bad), 16'd0);
`endif

        repeat (3) step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/vid_palette_dbuf.md
Name: vid_palette_dbuf

Overview:
Double-buffered, parametrised video palette with a front bank and a back bank.
- Video read port always reads the front bank; the CPU/bus write port always writes the back bank.
- A swap request is committed only at the next frame boundary, so palette changes never tear mid-frame.
- Sits between the pixel index stage and the colour output stage; configurable colour width, depth and read latency.

Parameters:
AW, 8, palette index width; depth = 2^AW entries per bank
DW, 16, colour entry width in bits
RD_LAT, 1, read latency in cycles from r_addr_0 to r_data_n; legal values 1 or 2

Ports:
clk  in  1  system/pixel clock
rst  in  1  synchronous active-high reset
w_addr  in  AW  back-bank write address
w_data  in  DW  back-bank write data
w_ena  in  1  write strobe; a write occurs when w_ena && w_ready
w_ready  out  1  write port can accept a write this cycle
swap_req  in  1  one-cycle pulse: request front/back exchange at next frame_start
swap_pending  out  1  swap requested but not yet committed
frame_start  in  1  one-cycle pulse at start of vertical blanking / frame boundary
r_addr_0  in  AW  front-bank read address
r_valid_0  in  1  read address qualifier
r_data_n  out  DW  front-bank colour, RD_LAT cycles after r_addr_0
r_valid_n  out  1  r_valid_0 delayed by RD_LAT cycles
bank_sel  out  1  index of current front bank (0/1)

Behaviour:
- Storage: 2 x 2^AW x DW, implemented as one RAM of 2^(AW+1) entries.
  - Read address {bank_sel, r_addr_0}; write address {~bank_sel, w_addr}.
  - One read and one write per cycle, no collision possible since the banks differ.
- Read path:
  - RD_LAT=1: registered RAM output.
  - RD_LAT=2: one extra output register.
  - r_valid_n follows the same pipeline; r_data_n holds its last value when r_valid_0 is low (no forced zero).
- Swap FSM states:
  - IDLE:
    - swap_req -> PENDING.
    - swap_req coincident with frame_start is not committed in that cycle; it goes to PENDING and commits at the following frame_start.
  - PENDING:
    - w_ready=0.
    - On frame_start: bank_sel toggles in that same cycle; next state IDLE.
    - Further swap_req pulses are ignored (no queueing).
- w_ready = 1 in IDLE, 0 in PENDING (and 0 in CLEAR when the optional feature is present).
  - w_ena while w_ready=0 is dropped; there is no side effect.
- Bank toggle takes effect for read addresses presented in the cycle after the toggle.
  - Reads already in the pipeline complete from the old bank.
- Reset values:
  - bank_sel=0, state IDLE, swap_pending=0, w_ready=1.
  - r_valid_n=0 and all pipeline valids 0; r_data_n=0.
  - RAM contents are not reset.
- Reset mid-PENDING: the swap is abandoned; bank_sel returns to 0.
- Back bank is not coherent with the front bank after a swap. Software rewrites all entries it needs before the next swap_req.

Optional Feature:
- Macro: VID_PALETTE_DBUF_CLEAR_EN.
- With it:
  - Extra input clr_req (1 bit, pulse) and FSM state CLEAR.
  - clr_req accepted only in IDLE. CLEAR writes 0 to back-bank entries 0..2^AW-1, one per cycle, via an AW-bit counter.
  - Exits to IDLE after the last entry (2^AW cycles).
  - w_ready=0 during CLEAR; swap_req during CLEAR is ignored.
  - Reset aborts the clear.
- Without it: no clr_req port, no CLEAR state.

Test Plan:
- Reset, then write back addr 0x05=0x1234 and swap_req, then frame_start. Required: bank_sel=1, then read 0x05 gives 0x1234 after RD_LAT cycles with r_valid_n=1.
- Read 0x05 continuously before frame_start. Required: old front value returned, never 0x1234; no change until the cycle after the toggle.
- swap_req, then w_ena at addr 0x10 during PENDING. Required: w_ready=0, write dropped, back bank 0x10 unchanged after swap.
- swap_req and frame_start in the same cycle. Required: swap_pending=1, bank_sel unchanged; commits at the next frame_start.
- Reset asserted while PENDING. Required: next cycle swap_pending=0, bank_sel=0, w_ready=1.
- CLEAR_EN, AW=8: write 0xFFFF everywhere, clr_req, wait 256 cycles, swap, read all. Required: all 0x0000, w_ready=0 for exactly 256 cycles.
